hs_amm_master: RTL

Single-clock Avalon-MM master that acts as the responder end of the request/acknowledge handshake. It sits in the slave clock domain behind the CDC handshake. It takes a level request plus a command word held stable by the requesting domain, runs one Avalon-MM read or write with waitrequest/readdatavalid flow control, and returns a one-cycle acknowledge once the transfer completes. Read data and the error flag are held until the next accepted request.

---
 rtl/hs_amm_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hs_amm_master.sv
// hs_amm_master: handshake responder that runs one Avalon-MM read or write per request.
// Define HS_AMM_TIMEOUT_EN to enable the CMD/RDATA watchdog and the stale read-beat filter.
module hs_amm_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                ack_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_address_i,
  input  logic [DATA_W-1:0]   cmd_writedata_i,
  input  logic [DATA_W/8-1:0] cmd_byteenable_i,
  output logic [DATA_W-1:0]   rsp_readdata_o,
  output logic                rsp_error_o,
  output logic [ADDR_W-1:0]   amm_address_o,
  output logic                amm_read_o,
  output logic                amm_write_o,
  output logic [DATA_W-1:0]   amm_writedata_o,
  output logic [DATA_W/8-1:0] amm_byteenable_o,
  input  logic                amm_waitrequest_i,
  input  logic [DATA_W-1:0]   amm_readdata_i,
  input  logic                amm_readdatavalid_i
);
  typedef enum logic [1:0] {IDLE, CMD, RDATA, DONE} state_t;
  if (TIMEOUT_CYCLES < 2 || DATA_W % 8 != 0) begin : g_bad_cfg
    $error("hs_amm_master: invalid TIMEOUT_CYCLES or DATA_W");
  end
  state_t state_q, state_d;
  logic write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic rdv;
`ifdef HS_AMM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stale_q, stale_d, err_q, err_d, tmo;
  // a beat belonging to a timed-out read must never complete a later read
  assign rdv = amm_readdatavalid_i & ~stale_q;
`else
  assign rdv = amm_readdatavalid_i;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
`ifdef HS_AMM_TIMEOUT_EN
      cnt_q   <= '0;
      stale_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
`ifdef HS_AMM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      err_q   <= err_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
`ifdef HS_AMM_TIMEOUT_EN
    stale_d = stale_q & ~amm_readdatavalid_i;
    err_d   = err_q;
    tmo     = (state_q == CMD || state_q == RDATA) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`endif
    case (state_q)
      IDLE: if (req_i) begin
        state_d = CMD;
        write_d = cmd_write_i;
        addr_d  = cmd_address_i;
        wdata_d = cmd_writedata_i;
        be_d    = cmd_byteenable_i;
`ifdef HS_AMM_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      CMD:     state_d = amm_waitrequest_i ? CMD : write_q ? DONE : RDATA;
      RDATA: if (rdv) begin
        state_d = DONE;
        rdata_d = amm_readdata_i;
      end
      default: state_d = IDLE;
    endcase
`ifdef HS_AMM_TIMEOUT_EN
    // data arriving on the timeout cycle still wins
    if (tmo && !(state_q == RDATA && rdv)) begin
      state_d = DONE;
      err_d   = 1'b1;
      if (!write_q) begin
        rdata_d = '0;
        stale_d = 1'b1;
      end
    end
    cnt_d = (state_d == state_q && (state_q == CMD || state_q == RDATA)) ? cnt_q + 1'b1 : '0;
`endif
  end
  always_comb begin
    ack_o            = state_q == DONE;
    amm_read_o       = state_q == CMD && !write_q;
    amm_write_o      = state_q == CMD && write_q;
    amm_address_o    = state_q == CMD ? addr_q : '0;
    amm_writedata_o  = state_q == CMD ? wdata_q : '0;
    amm_byteenable_o = state_q == CMD ? be_q : '0;
    rsp_readdata_o   = rdata_q;
`ifdef HS_AMM_TIMEOUT_EN
    rsp_error_o      = err_q;
`else
    rsp_error_o      = 1'b0;
`endif
  end
endmodule
